// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 shared constants, S-box table and GF(2^8) column mixing
package aes_pkg;

   localparam int NR           = 10;
   localparam int ROUND_CYCLES = 3;

   typedef enum logic {FSM_IDLE, FSM_ROUND} fsm_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Row byte 0 of the column sits in bits [7:0].
   function automatic logic [31:0] mixcolumn(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[7:0];
      a1 = col[15:8];
      a2 = col[23:16];
      a3 = col[31:24];
      b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      return {b3, b2, b1, b0};
   endfunction

endpackage

// File: rtl/aes_sbox_rom.sv
// rtl/aes_sbox_rom.sv - 256x8 dual-port S-box ROM with synchronous read
module aes_sbox_rom
   import aes_pkg::*;
(
   input  logic       clk_i,
   input  logic       en_i,
   input  logic [7:0] addr_a_i,
   input  logic [7:0] addr_b_i,
   output logic [7:0] data_a_o,
   output logic [7:0] data_b_o
);

   logic [7:0] data_a_q;
   logic [7:0] data_b_q;

   // No reset on the read registers so the ROM maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         data_a_q <= SBOX[addr_a_i];
         data_b_q <= SBOX[addr_b_i];
      end
   end

   assign data_a_o = data_a_q;
   assign data_b_o = data_b_q;

endmodule

// File: rtl/aes128_core_full.sv
// rtl/aes128_core_full.sv - AES-128 encryption core, 3-cycle rounds, host-streamed round keys
module aes128_core_full
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         kill,
   input  logic [127:0] in_data,
   input  logic         in_en,
   input  logic [127:0] key_round,
   output logic         key_ready,
   output logic [127:0] out_data,
   output logic         out_en
);

   fsm_e         fsm_q;
   logic [3:0]   round_q;
   logic [1:0]   phase_q;
   logic [127:0] state_q;
   logic [127:0] result_q;
   logic [127:0] out_data_q;
   logic         key_ready_q;
   logic         out_en_q;

   logic         rom_en;
   logic [127:0] sub_bytes;
   logic [127:0] shifted;
   logic [127:0] mixed;
   logic [127:0] result_d;

   assign rom_en = (fsm_q == FSM_ROUND) && (phase_q == 2'd0);

   // Each ROM serves two adjacent state bytes.
   for (genvar g = 0; g < 8; g++) begin : g_rom
      aes_sbox_rom u_rom (
         .clk_i    (clk),
         .en_i     (rom_en),
         .addr_a_i (state_q[16*g +: 8]),
         .addr_b_i (state_q[16*g+8 +: 8]),
         .data_a_o (sub_bytes[16*g +: 8]),
         .data_b_o (sub_bytes[16*g+8 +: 8])
      );
   end

   always_comb begin
      shifted = '0;
      mixed   = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[8*(4*c+r) +: 8] = sub_bytes[8*(4*((c+r)%4)+r) +: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mixed[32*c +: 32] = mixcolumn(shifted[32*c +: 32]);
      end
      result_d = (round_q == 4'(NR)) ? shifted : mixed;
   end

   always_ff @(posedge clk or negedge kill) begin
      if (!kill) begin
         fsm_q       <= FSM_IDLE;
         round_q     <= '0;
         phase_q     <= '0;
         state_q     <= '0;
         result_q    <= '0;
         out_data_q  <= '0;
         key_ready_q <= 1'b0;
         out_en_q    <= 1'b0;
      end else begin
         key_ready_q <= 1'b0;
         out_en_q    <= 1'b0;
         case (fsm_q)
            FSM_IDLE: begin
               if (in_en) begin
                  state_q     <= in_data ^ key_round;
                  round_q     <= 4'd1;
                  phase_q     <= 2'd0;
                  key_ready_q <= 1'b1;
                  fsm_q       <= FSM_ROUND;
               end
            end
            FSM_ROUND: begin
               case (phase_q)
                  2'd0: phase_q <= 2'd1;
                  2'd1: begin
                     result_q <= result_d;
                     phase_q  <= 2'(ROUND_CYCLES - 1);
                  end
                  2'd2: begin
                     state_q <= result_q ^ key_round;
                     phase_q <= 2'd0;
                     if (round_q == 4'(NR)) begin
                        out_data_q <= result_q ^ key_round;
                        out_en_q   <= 1'b1;
                        round_q    <= '0;
                        fsm_q      <= FSM_IDLE;
                     end else begin
                        round_q     <= round_q + 4'd1;
                        key_ready_q <= 1'b1;
                     end
                  end
                  default: begin
                     phase_q <= 2'd0;
                     fsm_q   <= FSM_IDLE;
                  end
               endcase
            end
            default: fsm_q <= FSM_IDLE;
         endcase
      end
   end

   assign key_ready = key_ready_q;
   assign out_data  = out_data_q;
   assign out_en    = out_en_q;

endmodule

// File: tb/tb_aes128_core_full.sv
// tb/tb_aes128_core_full.sv - self-checking bench for aes128_core_full against a field-arithmetic AES model
module tb_aes128_core_full;

   localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;

   logic         clk;
   logic         kill;
   logic [127:0] in_data;
   logic         in_en;
   logic [127:0] key_round;
   logic         key_ready;
   logic [127:0] out_data;
   logic         out_en;

   logic [7:0]   sb_ref [256];
   logic [127:0] rk [11];
   int           kidx;
   int           n_checks;
   int           n_pass;

   aes128_core_full dut (
      .clk       (clk),
      .kill      (kill),
      .in_data   (in_data),
      .in_en     (in_en),
      .key_round (key_round),
      .key_ready (key_ready),
      .out_data  (out_data),
      .out_en    (out_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Polynomial product followed by reduction modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
      for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x};
      return d[15-n -: 8];
   endfunction

   function automatic logic [7:0] mc_coef(input int d);
      case (d)
         0:       return 8'h02;
         1:       return 8'h03;
         default: return 8'h01;
      endcase
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            t = {sb_ref[t[31:24]], sb_ref[t[23:16]], sb_ref[t[15:8]], sb_ref[t[7:0]]};
            t[7:0] = t[7:0] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int k = 0; k < 11; k++) rk[k] = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
   endtask

   function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [127:0] res;
      for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ rk[0][8*k +: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int k = 0; k < 16; k++) t[k] = sb_ref[s[k]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
               for (int i = 0; i < 4; i++) begin
                  s[4*c+i] = 8'h00;
                  for (int j = 0; j < 4; j++) s[4*c+i] ^= gmul(mc_coef((j - i + 4) % 4), a[j]);
               end
            end
         end
         for (int k = 0; k < 16; k++) s[k] ^= rk[r][8*k +: 8];
      end
      for (int k = 0; k < 16; k++) res[8*k +: 8] = s[k];
      return res;
   endfunction

   // Host side of the key handshake: next round key one edge after each request.
   initial begin
      forever begin
         @(negedge clk);
         if (key_ready === 1'b1) begin
            @(posedge clk);
            #1;
            if (kidx < 10) kidx++;
            key_round = rk[kidx];
         end
      end
   end

   task automatic run_block(input logic [127:0] pt, input logic [127:0] exp, input int glitch_at,
                            input int kill_at, input bit chain, input string tag);
      int           kr_n;
      int           kr_bad;
      int           oe_n;
      int           oe_at;
      logic [127:0] got;
      kr_n   = 0;
      kr_bad = 0;
      oe_n   = 0;
      oe_at  = -1;
      got    = '0;
      in_data   = pt;
      in_en     = 1'b1;
      key_round = rk[0];
      kidx      = 0;
      @(posedge clk);
      #1;
      in_en   = 1'b0;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i <= 40; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         if (key_ready === 1'b1) begin
            if (i != 3 * kr_n) kr_bad++;
            kr_n++;
         end
         if (out_en === 1'b1) begin
            oe_n++;
            if (oe_at < 0) begin
               oe_at = i;
               got   = out_data;
            end
         end
         if (kill_at >= 0) begin
            if (i == kill_at) kill = 1'b0;
            if (i == kill_at + 1) begin
               check({tag, "_rst_out_data"}, out_data, '0);
               check({tag, "_rst_out_en"}, 128'(out_en), '0);
               check({tag, "_rst_key_ready"}, 128'(key_ready), '0);
            end
            if (i == kill_at + 2) kill = 1'b1;
         end
         if (i == glitch_at) begin
            in_en   = 1'b1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
         end else if (i == glitch_at + 1) begin
            in_en = 1'b0;
         end
         if (i == 35 && kill_at < 0) check({tag, "_held"}, out_data, exp);
         if (chain && i == 30) begin
            in_data   = pt;
            in_en     = 1'b1;
            key_round = rk[0];
            kidx      = 0;
            break;
         end
      end
      if (kill_at >= 0) begin
         check({tag, "_no_out_en"}, 128'(oe_n), 128'd0);
      end else begin
         check({tag, "_latency"}, 128'(oe_at), 128'd30);
         check({tag, "_out_data"}, got, exp);
         check({tag, "_out_en_count"}, 128'(oe_n), 128'd1);
         check({tag, "_kr_count"}, 128'(kr_n), 128'd10);
         check({tag, "_kr_spacing"}, 128'(kr_bad), 128'd0);
      end
   endtask

   initial begin
      logic [127:0] pt;
      logic [127:0] key;
      logic [127:0] exp;
      n_checks  = 0;
      n_pass    = 0;
      kidx      = 0;
      kill      = 1'b0;
      in_en     = 1'b0;
      in_data   = '0;
      key_round = '0;
      build_sbox();
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_data", out_data, '0);
      check("reset_out_en", 128'(out_en), '0);
      check("reset_key_ready", 128'(key_ready), '0);
      kill = 1'b1;
      @(posedge clk);
      #1;

      expand_key(C1_KEY);
      run_block(C1_PT, C1_CT, -1, -1, 1'b0, "c1");
      run_block(C1_PT, C1_CT, 10, -1, 1'b0, "ignored_start");
      run_block(C1_PT, C1_CT, -1, -1, 1'b1, "b2b_first");
      run_block(C1_PT, C1_CT, -1, -1, 1'b0, "b2b_second");

      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      run_block(pt, model_encrypt(pt), -1, 15, 1'b0, "kill");
      expand_key(C1_KEY);
      run_block(C1_PT, C1_CT, -1, -1, 1'b0, "after_kill");

      for (int n = 0; n < 6; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         expand_key(key);
         exp = model_encrypt(pt);
         run_block(pt, exp, (n % 2 == 1) ? int'($urandom_range(1, 28)) : -1, -1, 1'b0,
                   $sformatf("rand%0d", n));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
